// File: rtl/warp_table_fifo.sv
// Warp table queue: in-order FIFO of warp descriptors from scheduler to fetch, with a registered read port.
// Define WARP_TABLE_OVERFLOW_CHECK_EN to compile simulation-only overflow/underflow $error checks.
module warp_table_fifo #(
  parameter int DATA_W     = 44,
  parameter int DEPTH      = 32,
  parameter int VACANT_MIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic              write_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic [DATA_W-1:0] write_data,
  output logic              fifo_empty,
  output logic              fifo_vacant,
  output logic              fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] VACANT_C = (AW+1)'(VACANT_MIN);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  // Acceptance uses the pre-edge flags, so a full table drops a push even if a pop frees a slot.
  assign push_ok = write_en && !fifo_full;
  assign pop_ok  = read_en && !fifo_empty;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_C);
  assign fifo_vacant = ((DEPTH_C - count) >= VACANT_C);

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WARP_TABLE_OVERFLOW_CHECK_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (write_en && fifo_full) begin
        $error("warp_table_fifo: overflow, push while full");
      end
      if (read_en && fifo_empty) begin
        $error("warp_table_fifo: underflow, pop while empty");
      end
    end
  end
`endif

endmodule

// File: tb/tb_warp_table_fifo.sv
// Self-checking bench for warp_table_fifo against a queue-based reference model.
module tb_warp_table_fifo;

  localparam int DATA_W     = 44;
  localparam int DEPTH      = 32;
  localparam int VACANT_MIN = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read_en = 1'b0;
  logic              write_en = 1'b0;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic [DATA_W-1:0] write_data = '0;
  logic              fifo_empty;
  logic              fifo_vacant;
  logic              fifo_full;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_valid = 1'b0;

  warp_table_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .VACANT_MIN(VACANT_MIN)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .read_data(read_data), .read_valid(read_valid), .write_data(write_data),
    .fifo_empty(fifo_empty), .fifo_vacant(fifo_vacant), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  function automatic logic m_empty(); return model_q.size() == 0; endfunction
  function automatic logic m_full();  return model_q.size() == DEPTH; endfunction
  function automatic logic m_vacant(); return (DEPTH - model_q.size()) >= VACANT_MIN; endfunction

  // One clock with the given request; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic we, input logic re, input logic [DATA_W-1:0] wd);
    logic was_empty, was_full;
    was_empty = m_empty();
    was_full  = m_full();
    write_en   = we;
    read_en    = re;
    write_data = wd;
    if (re && !was_empty) begin
      exp_data  = model_q.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (we && !was_full) model_q.push_back(wd);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2);
    vectors++;
    if ({fifo_empty, fifo_full, fifo_vacant, read_valid} !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got e/f/v/rv=%b required 1010",
               {fifo_empty, fifo_full, fifo_vacant, read_valid});
    end
    vectors++;
    if (read_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h required 0", read_data);
    end
  endtask

  task automatic test_alternating();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 200; i++) begin
      d = rand_data();
      cycle(1'b1, 1'b0, d);
      vectors++;
      if (fifo_empty !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL alt_empty_after_push it=%0d: got %b required 0", i, fifo_empty);
      end
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (read_data !== d || read_valid !== 1'b1 || fifo_empty !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL alt_pop it=%0d: got data=%h rv=%b e=%b required data=%h rv=1 e=1",
                 i, read_data, read_valid, fifo_empty, d);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DATA_W'(i));
      vectors++;
      if (fifo_full !== (i == DEPTH-1) || fifo_vacant !== (i + 1 < 29) || fifo_empty !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_flags n=%0d: got f/v/e=%b%b%b required %b%b0", i + 1,
                 fifo_full, fifo_vacant, fifo_empty, (i == DEPTH-1), (i + 1 < 29));
      end
    end
    cycle(1'b1, 1'b0, 44'hABC);
    vectors++;
    if (fifo_full !== 1'b1 || read_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_drop: got f=%b rv=%b required f=1 rv=0", fifo_full, read_valid);
    end
    // Push during a pop while full is still dropped: occupancy drops to 31.
    cycle(1'b1, 1'b1, 44'hDEF);
    vectors++;
    if (read_data !== 44'd0 || read_valid !== 1'b1 || fifo_full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_push_pop: got data=%h rv=%b f=%b required 0/1/0",
               read_data, read_valid, fifo_full);
    end
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (read_data !== DATA_W'(i) || read_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL fill_order i=%0d: got %h rv=%b required %h rv=1",
                 i, read_data, read_valid, DATA_W'(i));
      end
    end
    vectors++;
    if (fifo_empty !== 1'b1 || fifo_vacant !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_drained: got e=%b v=%b required 1 1", fifo_empty, fifo_vacant);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rand_data());
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, rand_data());
      vectors++;
      if (read_data !== exp_data || read_valid !== 1'b1 || model_q.size() != 5 ||
          {fifo_empty, fifo_full, fifo_vacant} !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL simul it=%0d: got data=%h rv=%b efv=%b required data=%h rv=1 efv=001",
                 i, read_data, read_valid, {fifo_empty, fifo_full, fifo_vacant}, exp_data);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (read_data !== exp_data || read_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL simul_drain i=%0d: got %h required %h", i, read_data, exp_data);
      end
    end
  endtask

  task automatic test_pop_empty();
    logic [DATA_W-1:0] held;
    held = exp_data;
    cycle(1'b0, 1'b1, '0);
    vectors++;
    if (read_valid !== 1'b0 || read_data !== held || fifo_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pop_empty: got rv=%b data=%h e=%b required rv=0 data=%h e=1",
               read_valid, read_data, fifo_empty, held);
    end
    // Push and pop together while empty: only the push lands.
    cycle(1'b1, 1'b1, 44'h123);
    vectors++;
    if (read_valid !== 1'b0 || fifo_empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty_push_pop: got rv=%b e=%b required rv=0 e=0", read_valid, fifo_empty);
    end
    cycle(1'b0, 1'b1, '0);
    vectors++;
    if (read_data !== 44'h123 || read_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL empty_push_pop_read: got %h required 123", read_data);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, rand_data());
    do_reset(1);
    vectors++;
    if ({fifo_empty, fifo_full, fifo_vacant, read_valid} !== 4'b1010 || read_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset: got efvr=%b data=%h required 1010 data=0",
               {fifo_empty, fifo_full, fifo_vacant, read_valid}, read_data);
    end
    cycle(1'b1, 1'b0, 44'h5A5A);
    cycle(1'b0, 1'b1, '0);
    vectors++;
    if (read_data !== 44'h5A5A || read_valid !== 1'b1 || fifo_empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_reuse: got data=%h rv=%b e=%b required 5a5a/1/1",
               read_data, read_valid, fifo_empty);
    end
  endtask

  task automatic test_random();
    logic we, re;
    for (int i = 0; i < 600; i++) begin
      // Bias toward pushes early and pops late so both boundaries are visited.
      we = ($urandom_range(99) < (i < 300 ? 70 : 30));
      re = ($urandom_range(99) < (i < 300 ? 30 : 70));
      cycle(we, re, rand_data());
      vectors++;
      if (read_valid !== exp_valid || (exp_valid && read_data !== exp_data) ||
          {fifo_empty, fifo_full, fifo_vacant} !== {m_empty(), m_full(), m_vacant()}) begin
        miscompares++;
        $display("[TB] FAIL random it=%0d: got rv=%b data=%h efv=%b required rv=%b data=%h efv=%b",
                 i, read_valid, read_data, {fifo_empty, fifo_full, fifo_vacant},
                 exp_valid, exp_data, {m_empty(), m_full(), m_vacant()});
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alternating();
    test_fill();
    test_simultaneous();
    test_pop_empty();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
